btn_blink_sequencer: RTL and testbench
======================================

Name: btn_blink_sequencer

Overview:
- Consumes the single-cycle press pulse from the button conditioning stage and blinks one LED a programmable number of times.
- Each blink is a fixed ON interval followed by a fixed OFF interval, with cycle-exact timing from a down-counter.
- Sits between the button one-shot stage and the board LED pin on the Tang9k. The 27 MHz clock is a top-level concern; this block works only in cycles.

Parameters:
- ON_CYCLES, 13500000, clock cycles the LED is lit per blink; must be >= 1.
- OFF_CYCLES, 13500000, clock cycles the LED is dark after each blink; must be >= 1.
- CNT_W, 24, timer width; must satisfy 2^CNT_W > max(ON_CYCLES, OFF_CYCLES).
- LED_ACTIVE_LOW, 1, 1 = oLed driven low when lit (Tang9k LEDs); 0 = high when lit.

Ports:
- CLK  input  1  system clock, all logic on the rising edge.
- RESETn  input  1  asynchronous active-low reset.
- iTrig  input  1  one-cycle start pulse from the button one-shot stage.
- iCount  input  4  number of blinks, sampled only when a trigger is accepted.
- oLed  output  1  LED drive; polarity set by LED_ACTIVE_LOW.
- oBusy  output  1  high while a sequence is in progress.
- oDone  output  1  one-cycle pulse at sequence end.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, applied via RESETn on CLK.
- While RESETn = 0: state = IDLE, timer = 0, remaining = 0, LED unlit (oLed = LED_ACTIVE_LOW), oBusy = 0, oDone = 0.
- Reset asserted mid-sequence aborts immediately. No oDone is issued.
- All outputs are registered.
- States: IDLE, ON, OFF, DONE.
- IDLE, iTrig = 1:
  - Latch remaining = iCount.
  - If iCount = 0: go to DONE (empty sequence, LED never lit).
  - Otherwise: go to ON and load timer = ON_CYCLES-1.
  - Trigger sampled at edge t means the LED is lit from edge t+1 (1-cycle latency).
- ON:
  - LED lit. Timer decrements each cycle.
  - At timer = 0: remaining -= 1, go to OFF, load timer = OFF_CYCLES-1.
  - LED is therefore lit for exactly ON_CYCLES cycles.
- OFF:
  - LED unlit. Timer decrements each cycle.
  - At timer = 0: if remaining = 0 go to DONE, else go to ON and reload timer = ON_CYCLES-1.
  - The final blink is also followed by a full OFF interval, which guarantees a gap before any next sequence.
- DONE:
  - oDone = 1 for exactly one cycle, then go to IDLE.
  - New triggers are accepted from the IDLE cycle after DONE onward.
- oBusy = 1 in ON, OFF and DONE; 0 in IDLE.
- Sequence length for N >= 1: N*(ON_CYCLES+OFF_CYCLES) cycles of ON/OFF, then 1 DONE cycle.
- Triggers in ON, OFF or DONE are ignored unless BLINK_RETRIGGER_EN is defined. iCount is don't-care except in the accepting cycle.
- Timer arithmetic is unsigned CNT_W bits and never underflows; reload happens at 0.
- remaining is 4 bits, so at most 15 blinks per trigger.

Optional Feature:
- Macro: BLINK_RETRIGGER_EN.
- Defined:
  - iTrig = 1 in ON or OFF restarts the sequence.
  - remaining is reloaded from iCount and timer = ON_CYCLES-1; the state goes to ON next cycle, or to DONE if iCount = 0.
  - No oDone is issued for the aborted sequence.
  - iTrig in DONE is still ignored.
- Not defined: triggers outside IDLE are dropped with no side effects.

Test Plan:
All scenarios use ON_CYCLES=4, OFF_CYCLES=3, LED_ACTIVE_LOW=0.
1. Reset, then iTrig pulse at edge 10 with iCount=2 -> oLed=1 on cycles 11-14 and 18-21, 0 otherwise. oBusy=1 on cycles 11-25. oDone=1 on cycle 25 only.
2. iTrig with iCount=0 -> oLed stays 0. oBusy=1 and oDone=1 for the single cycle after the trigger, then IDLE.
3. iTrig with iCount=1, then a second iTrig 5 cycles later (macro undefined) -> one blink only (4 cycles lit, 3 dark) and exactly one oDone.
4. Same stimulus as 3 with BLINK_RETRIGGER_EN and iCount=3 on the second pulse -> first blink truncated, then 3 full blinks, then a single oDone.
5. RESETn pulled low for 2 cycles during the second ON interval of an iCount=3 sequence -> oLed, oBusy and oDone go to 0 immediately (asynchronous), no oDone. A fresh trigger after release produces a clean sequence.
6. LED_ACTIVE_LOW=1 with iCount=1 -> oLed=1 after reset, 0 for 4 cycles, 1 afterwards.

Source files
------------

// File: rtl/btn_blink_sequencer.sv
// Blinks one LED iCount times per accepted trigger: ON_CYCLES lit, then OFF_CYCLES dark.
// Define BLINK_RETRIGGER_EN to let a trigger during ON/OFF restart the sequence.
module btn_blink_sequencer #(
  parameter int unsigned ON_CYCLES      = 13500000,
  parameter int unsigned OFF_CYCLES     = 13500000,
  parameter int unsigned CNT_W          = 24,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       iTrig,
  input  logic [3:0] iCount,
  output logic       oLed,
  output logic       oBusy,
  output logic       oDone
);

  localparam logic [CNT_W-1:0] OnLoad  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OffLoad = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimerOne = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StOn, StOff, StDone} state_e;

  state_e           stateQ, stateD;
  logic [CNT_W-1:0] timerQ, timerD;
  logic [3:0]       remainQ, remainD;
  logic             acceptTrig;

`ifdef BLINK_RETRIGGER_EN
  assign acceptTrig = iTrig && (stateQ == StIdle || stateQ == StOn || stateQ == StOff);
`else
  assign acceptTrig = iTrig && (stateQ == StIdle);
`endif

  always_comb begin
    stateD  = stateQ;
    timerD  = timerQ;
    remainD = remainQ;
    unique case (stateQ)
      StIdle: ;
      StOn: begin
        if (timerQ == '0) begin
          remainD = remainQ - 4'd1;
          stateD  = StOff;
          timerD  = OffLoad;
        end else begin
          timerD = timerQ - TimerOne;
        end
      end
      StOff: begin
        if (timerQ == '0) begin
          if (remainQ == 4'd0) begin
            stateD = StDone;
            timerD = '0;
          end else begin
            stateD = StOn;
            timerD = OnLoad;
          end
        end else begin
          timerD = timerQ - TimerOne;
        end
      end
      StDone: stateD = StIdle;
      default: stateD = StIdle;
    endcase
    // An accepted trigger overrides whatever the running sequence would do next.
    if (acceptTrig) begin
      remainD = iCount;
      if (iCount == 4'd0) begin
        stateD = StDone;
        timerD = '0;
      end else begin
        stateD = StOn;
        timerD = OnLoad;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      stateQ  <= StIdle;
      timerQ  <= '0;
      remainQ <= 4'd0;
    end else begin
      stateQ  <= stateD;
      timerQ  <= timerD;
      remainQ <= remainD;
    end
  end

  // Outputs are registered copies of the current state, hence one cycle behind it.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      oLed  <= LED_ACTIVE_LOW;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oLed  <= (stateQ == StOn) ^ LED_ACTIVE_LOW;
      oBusy <= (stateQ != StIdle);
      oDone <= (stateQ == StDone);
    end
  end

endmodule

// File: tb/tb_btn_blink_sequencer.sv
// Bench for btn_blink_sequencer: directed scenarios plus random triggers against a
// timeline model (trigger cycle and count -> expected waveform). Honours BLINK_RETRIGGER_EN.
module tb_btn_blink_sequencer;

  localparam int OnC  = 4;
  localparam int OffC = 3;
  localparam int Per  = OnC + OffC;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       iTrig = 1'b0;
  logic [3:0] iCount = 4'd0;
  logic       led0, busy0, done0;
  logic       led1, busy1, done1;

  int cyc = 0;
  int trigCyc = -1;
  int trigN = 0;
  int nCmp = 0;
  int nBad = 0;

  always #5 CLK = ~CLK;

  btn_blink_sequencer #(
    .ON_CYCLES(OnC), .OFF_CYCLES(OffC), .CNT_W(8), .LED_ACTIVE_LOW(1'b0)
  ) dutHigh (
    .CLK(CLK), .RESETn(RESETn), .iTrig(iTrig), .iCount(iCount),
    .oLed(led0), .oBusy(busy0), .oDone(done0)
  );

  btn_blink_sequencer #(
    .ON_CYCLES(OnC), .OFF_CYCLES(OffC), .CNT_W(8), .LED_ACTIVE_LOW(1'b1)
  ) dutLow (
    .CLK(CLK), .RESETn(RESETn), .iTrig(iTrig), .iCount(iCount),
    .oLed(led1), .oBusy(busy1), .oDone(done1)
  );

  // Model: the last accepted trigger at edge trigCyc with trigN blinks fixes the timeline.
  function automatic int relOf(int c);
    return c - trigCyc - 1;
  endfunction

  function automatic logic expLit(int c);
    int rel = relOf(c);
    return (trigCyc >= 0 && rel >= 0 && rel < Per * trigN && (rel % Per) < OnC);
  endfunction

  function automatic logic expBusy(int c);
    int rel = relOf(c);
    return (trigCyc >= 0 && rel >= 0 && rel <= Per * trigN);
  endfunction

  function automatic logic expDone(int c);
    return (trigCyc >= 0 && relOf(c) == Per * trigN);
  endfunction

  function automatic bit idleAt(int e);
    return (trigCyc < 0 || e >= trigCyc + Per * trigN + 2);
  endfunction

  function automatic bit runningAt(int e);
    return (trigCyc >= 0 && trigN > 0 && e >= trigCyc + 1 && e <= trigCyc + Per * trigN);
  endfunction

  task automatic checkOne(input string tag, input logic obs, input logic exp);
    nCmp++;
    assert (obs === exp)
    else begin
      nBad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOne("led", led0, expLit(cyc));
    checkOne("busy", busy0, expBusy(cyc));
    checkOne("done", done0, expDone(cyc));
    checkOne("ledActiveLow", led1, ~expLit(cyc));
    checkOne("busyActiveLow", busy1, expBusy(cyc));
  endtask

  // Drive inputs for the next rising edge, update the model, then check on the falling edge.
  task automatic step(input logic trig, input logic [3:0] cnt);
    bit acc;
    iTrig = trig;
    iCount = cnt;
    @(posedge CLK);
    if (RESETn) begin
      cyc++;
      acc = idleAt(cyc);
`ifdef BLINK_RETRIGGER_EN
      acc = acc || runningAt(cyc);
`endif
      if (trig && acc) begin
        trigCyc = cyc;
        trigN = int'(cnt);
      end
    end
    @(negedge CLK);
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'($urandom_range(0, 15)));
  endtask

  // Asynchronous reset mid-cycle: outputs must clear without waiting for a clock edge.
  task automatic pulseReset(input int hold);
    #2;
    RESETn = 1'b0;
    #1;
    trigCyc = -1;
    checkOne("asyncLed", led0, 1'b0);
    checkOne("asyncBusy", busy0, 1'b0);
    checkOne("asyncDone", done0, 1'b0);
    checkOne("asyncLedActiveLow", led1, 1'b1);
    for (int i = 0; i < hold; i++) step(1'b1, 4'd5);
    RESETn = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    checkAll();
    RESETn = 1'b1;

    // Trigger at edge 10 with two blinks.
    idle(9);
    step(1'b1, 4'd2);
    idle(20);

    // Empty sequence.
    step(1'b1, 4'd0);
    idle(4);

    // Second trigger five cycles into a single blink.
    step(1'b1, 4'd1);
    idle(4);
    step(1'b1, 4'd3);
    idle(30);

    // Reset during the second ON interval of a three-blink sequence, then a clean run.
    step(1'b1, 4'd3);
    idle(9);
    pulseReset(2);
    step(1'b1, 4'd2);
    idle(20);

    // Trigger on the DONE-output cycle and immediately after it.
    step(1'b1, 4'd1);
    idle(Per);
    step(1'b1, 4'd1);
    step(1'b1, 4'd1);
    idle(Per + 3);

    // Random triggers and counts, with one reset in the middle.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
      if (i == 400) pulseReset(1);
    end
    idle(120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
